// File: rtl/sound_mixer.sv
// sound_mixer: priority-arbitrates square-wave sources onto one speaker pin with glitch-free switching, PWM volume and mute
module sound_mixer #(
  parameter int NUM_SRC      = 3,
  parameter int IDLE_TIMEOUT = 262144,
  parameter int TO_W         = 19,
  parameter int VOL_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_wave,
  input  logic               mute,
  input  logic [VOL_W-1:0]   volume,
  output logic               audio_out,
  output logic [1:0]         owner,
  output logic               busy
);
  localparam logic [TO_W-1:0] TO = TO_W'(IDLE_TIMEOUT);
  typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;
  state_t state, state_n;
  logic [1:0] owner_n, desired;
  logic [NUM_SRC-1:0] prev_wave, active;
  logic [TO_W-1:0] timer [NUM_SRC];
  logic [3:0] wave4, act4;
  logic [VOL_W-1:0] pwm_cnt;
  logic none_active, pwm_on, busy_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_wave <= '0;
      for (int i = 0; i < NUM_SRC; i++) timer[i] <= TO;
    end else begin
      prev_wave <= src_wave;
      for (int i = 0; i < NUM_SRC; i++)
        timer[i] <= (src_wave[i] != prev_wave[i]) ? '0 : (timer[i] < TO) ? timer[i] + 1'b1 : TO;
    end
  always_comb begin
    desired = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      active[i] = timer[i] < TO;
      if (active[i]) desired = 2'(i);
    end
  end
  assign none_active = ~|active;
  assign wave4 = 4'(src_wave);
  assign act4 = 4'(active);
  always_comb begin
    state_n = state;
    owner_n = owner;
    case (state)
      IDLE: if (!none_active) begin
        state_n = PLAY;
        owner_n = desired;
      end
      PLAY: if (desired != owner || !act4[owner]) begin
        if (!wave4[owner]) begin
          owner_n = desired;
          state_n = none_active ? IDLE : PLAY;
        end else state_n = HOLD;
      end
      HOLD: if (!wave4[owner] || !act4[owner]) begin
        owner_n = desired;
        state_n = none_active ? IDLE : PLAY;
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy_n = state_n != IDLE;
  assign pwm_on = (&volume) | (pwm_cnt < volume);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      audio_out <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      audio_out <= busy_n & ~mute & wave4[owner_n] & pwm_on;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
endmodule

// File: tb/tb_sound_mixer.sv
// tb_sound_mixer: directed scenarios checked every cycle against a cycle-level behavioural model of the mixer
module tb_sound_mixer;
  localparam int TO = 64;
  logic clk = 0;
  logic rst_n = 0;
  logic [2:0] src_wave = '0;
  logic mute = 0;
  logic [3:0] volume = 4'd15;
  logic audio_out, busy;
  logic [1:0] owner;
  int vectors = 0;
  int miscompares = 0;
  int per [3] = '{0, 0, 0};
  int cnt [3] = '{0, 0, 0};
  bit lvl [3] = '{0, 0, 0};
  int since [3];
  bit prv [3];
  int mode, mown, maud, pc;

  sound_mixer #(.NUM_SRC(3), .IDLE_TIMEOUT(TO), .TO_W(7), .VOL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .src_wave(src_wave), .mute(mute), .volume(volume),
    .audio_out(audio_out), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // wave generator: per[i]==0 holds lvl[i], otherwise toggles every per[i] cycles
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++)
      if (per[i] == 0) begin
        cnt[i] = 0;
        src_wave[i] = lvl[i];
      end else begin
        cnt[i] = cnt[i] + 1;
        if (cnt[i] >= per[i]) begin
          cnt[i] = 0;
          src_wave[i] = ~src_wave[i];
        end
      end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // model: mode 0=idle 1=playing 2=holding; since[i] = cycles since last edge, capped at TO
  always @(posedge clk or negedge rst_n) begin
    bit act [3];
    bit none, want, w, pon;
    int des, nm, no;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        since[i] = TO;
        prv[i] = 0;
      end
      mode = 0; mown = 0; maud = 0; pc = 0;
    end else begin
      none = 1;
      des = 0;
      for (int i = 0; i < 3; i++) begin
        act[i] = since[i] < TO;
        if (act[i]) begin
          des = i;
          none = 0;
        end
      end
      nm = mode;
      no = mown;
      w = src_wave[mown];
      want = (des != mown) || !act[mown];
      if (mode == 0) begin
        if (!none) begin
          nm = 1;
          no = des;
        end
      end else if (mode == 2 ? (!w || !act[mown]) : (want && !w)) begin
        no = des;
        nm = none ? 0 : 1;
      end else if (mode == 1 && want) nm = 2;
      pon = (volume == 15) || (pc < int'(volume));
      maud = int'(nm != 0 && !mute && src_wave[no] && pon);
      for (int i = 0; i < 3; i++) begin
        since[i] = (src_wave[i] != prv[i]) ? 0 : (since[i] < TO ? since[i] + 1 : TO);
        prv[i] = src_wave[i];
      end
      pc = (pc + 1) % 16;
      mode = nm;
      mown = no;
    end
  end

  always @(negedge clk)
    if (rst_n) begin
      chk("model_audio", int'(audio_out), maud);
      chk("model_owner", int'(owner), mown);
      chk("model_busy", int'(busy), int'(mode != 0));
    end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_src(input int i, input bit v);
    int k;
    k = 0;
    while (src_wave[i] !== v && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wait_src", int'(src_wave[i]), int'(v));
  endtask

  initial begin
    int c;
    bit last;
    int vols [3] = '{0, 4, 15};
    int duty [3] = '{0, 4, 16};
    wt(3);
    chk("rst_audio", int'(audio_out), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1;
    // 1: single source follows its input with one cycle of latency
    per[0] = 10;
    wt(30);
    chk("t1_busy", int'(busy), 1);
    chk("t1_owner", int'(owner), 0);
    last = src_wave[0];
    repeat (20) begin
      @(negedge clk);
      chk("t1_follow", int'(audio_out), int'(last));
      last = src_wave[0];
    end
    per[0] = 0;
    lvl[0] = 0;
    wt(75);
    chk("t1_idle_busy", int'(busy), 0);
    chk("t1_idle_audio", int'(audio_out), 0);
    // 2: higher priority arrives during a high phase
    per[0] = 10;
    wt(25);
    wait_src(0, 0);
    wait_src(0, 1);
    wt(2);
    per[2] = 2;
    wt(4);
    chk("t2_hold_owner", int'(owner), 0);
    chk("t2_hold_busy", int'(busy), 1);
    wait_src(0, 0);
    wt(3);
    chk("t2_new_owner", int'(owner), 2);
    // 3: high priority goes quiet, falls back to source 0
    per[2] = 0;
    lvl[2] = 0;
    wt(75);
    chk("t3_owner", int'(owner), 0);
    chk("t3_busy", int'(busy), 1);
    per[0] = 0;
    lvl[0] = 0;
    wt(75);
    chk("t4_pre_busy", int'(busy), 0);
    // 4: stuck-high input plays for its activity window then is silenced
    lvl[1] = 1;
    c = 0;
    repeat (80) begin
      @(negedge clk);
      if (audio_out) c++;
    end
    chk("t4_high_cycles", c, 65);
    chk("t4_busy", int'(busy), 0);
    chk("t4_audio", int'(audio_out), 0);
    chk("t4_owner", int'(owner), 0);
    lvl[1] = 0;
    wt(75);
    // 5: PWM duty sweep, then mute
    for (int v = 0; v < 4; v++) begin
      lvl[0] = 0;
      wt(2);
      lvl[0] = 1;
      volume = (v == 3) ? 4'd15 : 4'(vols[v]);
      mute = (v == 3);
      wt(3);
      c = 0;
      repeat (16) begin
        @(negedge clk);
        if (audio_out) c++;
      end
      chk(v == 3 ? "t5_mute" : "t5_duty", c, v == 3 ? 0 : duty[v]);
    end
    mute = 0;
    volume = 4'd15;
    lvl[0] = 0;
    wt(75);
    // 6: asynchronous reset in the middle of a high phase
    per[2] = 10;
    wt(25);
    wait_src(2, 1);
    @(posedge clk);
    #2;
    chk("t6_pre_audio", int'(audio_out), 1);
    #1 rst_n = 0;
    #1;
    chk("t6_async_audio", int'(audio_out), 0);
    chk("t6_async_busy", int'(busy), 0);
    per[2] = 0;
    lvl[2] = 0;
    wt(3);
    rst_n = 1;
    wt(10);
    chk("t6_quiet_busy", int'(busy), 0);
    chk("t6_quiet_audio", int'(audio_out), 0);
    per[2] = 10;
    wt(25);
    chk("t6_resume_busy", int'(busy), 1);
    chk("t6_resume_owner", int'(owner), 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
